// File: rtl/y_mem_writeback.sv
// rtl/y_mem_writeback.sv - Y SRAM read-modify-write of updated (col, value) entries
module y_mem_writeback #(
  parameter int          ADDR_W    = 11,
  parameter int          SLOTS     = 4,
  parameter logic [15:0] EMPTY_COL = 16'hFFFF,
  parameter int          RD_LAT    = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wb_inValid,
  output logic                  wb_inReady,
  input  logic [ADDR_W-1:0]     wb_addr,
  input  logic [15:0]           wb_col,
  input  logic [47:0]           wb_yVal,
  input  logic                  wb_last,
  input  logic [SLOTS*64-1:0]   ymem_rdData,
  output logic [ADDR_W-1:0]     ymem_addr,
  output logic                  ymem_rdEn,
  output logic                  ymem_wrEn,
  output logic [SLOTS*64-1:0]   ymem_wrData,
  output logic                  wb_done,
  output logic                  wb_err,
  output logic [15:0]           wb_wrCount
);

  localparam int ROW_W = SLOTS * 64;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    WAIT  = 3'd2,
    MERGE = 3'd3,
    WR    = 3'd4
  } state_t;

  state_t state;
  state_t next_state;

  // Captured entry; the row address itself lives in ymem_addr.
  logic [15:0]      cap_col;
  logic [47:0]      cap_val;
  logic             cap_last;
  logic [ROW_W-1:0] row;
  logic [1:0]       wait_cnt;

  // Control decoded by the FSM for the datapath register block.
  logic accept;
  logic sample_row;
  logic set_err;
  logic set_done;

  // Merge results.
  logic [SLOTS-1:0] hit_vec;
  logic [SLOTS-1:0] empty_vec;
  logic [SLOTS-1:0] cand_vec;
  logic [SLOTS-1:0] sel_vec;
  logic             overflow;
  logic [ROW_W-1:0] merged;

  // The ready is combinational so the sender sees it drop during reset.
  assign wb_inReady = (state == IDLE) && reset;

  // Merge target: a matching column wins; otherwise the lowest empty slot.
  // The captured column is never EMPTY_COL here, so both vectors are disjoint.
  always_comb begin
    hit_vec   = '0;
    empty_vec = '0;
    merged    = row;
    for (int i = 0; i < SLOTS; i++) begin
      hit_vec[i]   = (row[64*i+48 +: 16] == cap_col);
      empty_vec[i] = (row[64*i+48 +: 16] == EMPTY_COL);
    end
    cand_vec = (|hit_vec) ? hit_vec : empty_vec;
    sel_vec  = cand_vec & (~cand_vec + {{(SLOTS-1){1'b0}}, 1'b1});
    overflow = ~|cand_vec;
    for (int i = 0; i < SLOTS; i++) begin
      if (sel_vec[i]) begin
        merged[64*i +: 64] = {cap_col, cap_val};
      end
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and per-state control decode.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    sample_row = 1'b0;
    set_err    = 1'b0;
    set_done   = 1'b0;
    case (state)
      IDLE: begin
        if (wb_inValid && wb_inReady) begin
          accept = 1'b1;
          if (wb_col == EMPTY_COL) begin
            set_err  = 1'b1;
            set_done = wb_last;
          end else begin
            next_state = RD;
          end
        end
      end
      RD: begin
        next_state = WAIT;
      end
      WAIT: begin
        if (wait_cnt == 2'(RD_LAT - 1)) begin
          sample_row = 1'b1;
          next_state = MERGE;
        end
      end
      MERGE: begin
        if (overflow) begin
          set_err    = 1'b1;
          next_state = IDLE;
        end else begin
          next_state = WR;
        end
      end
      WR: begin
        set_done   = cap_last;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Datapath and registered outputs; strobes follow the state being entered
  // so each is high for exactly the cycle spent in RD or WR.
  always_ff @(posedge clock) begin
    if (!reset) begin
      ymem_addr   <= '0;
      ymem_rdEn   <= 1'b0;
      ymem_wrEn   <= 1'b0;
      ymem_wrData <= '0;
      wb_done     <= 1'b0;
      wb_err      <= 1'b0;
      wb_wrCount  <= '0;
      cap_col     <= '0;
      cap_val     <= '0;
      cap_last    <= 1'b0;
      row         <= '0;
      wait_cnt    <= '0;
    end else begin
      ymem_rdEn <= (next_state == RD);
      ymem_wrEn <= (next_state == WR);
      if (accept) begin
        ymem_addr <= wb_addr;
        cap_col   <= wb_col;
        cap_val   <= wb_yVal;
        cap_last  <= wb_last;
      end
      if (state == RD) begin
        wait_cnt <= '0;
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt + 2'd1;
      end
      if (sample_row) begin
        row <= ymem_rdData;
      end
      if (state == MERGE && !overflow) begin
        ymem_wrData <= merged;
      end
      if (set_err) begin
        wb_err <= 1'b1;
      end
      if (set_done) begin
        wb_done <= 1'b1;
      end
      if (state == WR && wb_wrCount != 16'hFFFF) begin
        wb_wrCount <= wb_wrCount + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_y_mem_writeback.sv
// tb/tb_y_mem_writeback.sv - self-checking bench for y_mem_writeback
module tb_y_mem_writeback;

  logic         clock;
  logic         reset;
  logic         wb_inValid;
  logic         wb_inReady;
  logic [10:0]  wb_addr;
  logic [15:0]  wb_col;
  logic [47:0]  wb_yVal;
  logic         wb_last;
  logic [255:0] ymem_rdData;
  logic [10:0]  ymem_addr;
  logic         ymem_rdEn;
  logic         ymem_wrEn;
  logic [255:0] ymem_wrData;
  logic         wb_done;
  logic         wb_err;
  logic [15:0]  wb_wrCount;

  int tests_run = 0;
  int tests_failed = 0;

  y_mem_writeback dut (
    .clock(clock), .reset(reset),
    .wb_inValid(wb_inValid), .wb_inReady(wb_inReady),
    .wb_addr(wb_addr), .wb_col(wb_col), .wb_yVal(wb_yVal), .wb_last(wb_last),
    .ymem_rdData(ymem_rdData), .ymem_addr(ymem_addr), .ymem_rdEn(ymem_rdEn),
    .ymem_wrEn(ymem_wrEn), .ymem_wrData(ymem_wrData),
    .wb_done(wb_done), .wb_err(wb_err), .wb_wrCount(wb_wrCount)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // SRAM with one cycle read latency, plus a preload port for the bench.
  logic [255:0] mem [0:2047];
  logic         pre_en = 1'b0;
  logic [10:0]  pre_addr = '0;
  logic [255:0] pre_data = '0;
  always @(posedge clock) begin
    if (ymem_rdEn) ymem_rdData <= mem[ymem_addr];
    if (pre_en) mem[pre_addr] = pre_data;
    if (ymem_wrEn) mem[ymem_addr] = ymem_wrData;
  end

  // Strobe monitor.
  int cyc = 0, rd_pulses = 0, wr_pulses = 0, rd_cyc = 0, wr_cyc = 0;
  int both_cnt = 0, idle_strobe = 0;
  logic rd_prev = 1'b0;
  logic [255:0] last_rd_data = '0;
  always @(negedge clock) begin
    cyc++;
    if (rd_prev) last_rd_data = ymem_rdData;
    rd_prev = ymem_rdEn;
    if (ymem_rdEn) begin rd_pulses++; rd_cyc = cyc; end
    if (ymem_wrEn) begin wr_pulses++; wr_cyc = cyc; end
    if (ymem_rdEn && ymem_wrEn) both_cnt++;
    if (wb_inReady && (ymem_rdEn || ymem_wrEn)) idle_strobe++;
  end

  // Reference model: expected row contents and status.
  logic [255:0] ref_mem [int];
  int   ref_count;
  logic ref_err, ref_done;

  function automatic void model_merge(input logic [255:0] r, input logic [15:0] col,
                                      input logic [47:0] val, output logic [255:0] nr,
                                      output logic ovf);
    logic [15:0] cols [4];
    int tgt = -1;
    for (int i = 0; i < 4; i++) cols[i] = r[64*i+48 +: 16];
    for (int i = 0; i < 4; i++) if (tgt < 0 && cols[i] == col) tgt = i;
    for (int i = 0; i < 4; i++) if (tgt < 0 && cols[i] == 16'hFFFF) tgt = i;
    nr  = r;
    ovf = (tgt < 0);
    if (!ovf) nr[64*tgt +: 64] = {col, val};
  endfunction

  task automatic model_entry(input int a, input logic [15:0] col, input logic [47:0] val,
                             input logic last);
    logic [255:0] nr;
    logic ovf;
    if (col == 16'hFFFF) begin
      ref_err = 1'b1;
      if (last) ref_done = 1'b1;
    end else begin
      model_merge(ref_mem[a], col, val, nr, ovf);
      if (ovf) ref_err = 1'b1;
      else begin
        ref_mem[a] = nr;
        if (ref_count < 65535) ref_count++;
        if (last) ref_done = 1'b1;
      end
    end
  endtask

  task automatic preload(input int a, input logic [255:0] d);
    @(negedge clock);
    pre_en = 1'b1; pre_addr = 11'(a); pre_data = d;
    @(negedge clock);
    pre_en = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0; wb_inValid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    ref_count = 0; ref_err = 1'b0; ref_done = 1'b0;
  endtask

  // Present an entry and return just after the accepting edge.
  task automatic send_entry(input int a, input logic [15:0] col, input logic [47:0] val,
                            input logic last);
    int n = 0;
    @(negedge clock);
    wb_inValid = 1'b1; wb_addr = 11'(a); wb_col = col; wb_yVal = val; wb_last = last;
    while (!wb_inReady && n < 50) begin @(negedge clock); n++; end
    if (!wb_inReady) begin
      tests_run++; tests_failed++;
      $display("FAIL send_timeout: ready=%b required 1", wb_inReady);
    end
    @(posedge clock);
    #1 wb_inValid = 1'b0;
  endtask

  // Count negedges until ready returns.
  task automatic wait_idle(output int n);
    n = 0;
    do begin @(negedge clock); n++; end while (!wb_inReady && n < 50);
    if (!wb_inReady) begin
      tests_run++; tests_failed++;
      $display("FAIL idle_timeout: ready=%b required 1", wb_inReady);
    end
  endtask

  task automatic check_status(input string tag);
    tests_run++;
    if (wb_wrCount !== 16'(ref_count)) begin
      tests_failed++; $display("FAIL %s_count: got %0d required %0d", tag, wb_wrCount, ref_count);
    end
    tests_run++;
    if ({wb_err, wb_done} !== {ref_err, ref_done}) begin
      tests_failed++; $display("FAIL %s_flags: got err=%b done=%b required err=%b done=%b",
                               tag, wb_err, wb_done, ref_err, ref_done);
    end
  endtask

  task automatic test_reset();
    int rd0 = rd_pulses, wr0 = wr_pulses;
    wb_inValid = 1'b1; wb_addr = 11'h005; wb_col = 16'd3; wb_yVal = '0; wb_last = 1'b1;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      tests_run++;
      if ({ymem_rdEn, ymem_wrEn, wb_done, wb_err, wb_inReady} !== 5'b0) begin
        tests_failed++;
        $display("FAIL reset_bits: got rd=%b wr=%b done=%b err=%b ready=%b required all 0",
                 ymem_rdEn, ymem_wrEn, wb_done, wb_err, wb_inReady);
      end
      tests_run++;
      if (ymem_addr !== 11'd0 || ymem_wrData !== 256'd0 || wb_wrCount !== 16'd0) begin
        tests_failed++;
        $display("FAIL reset_regs: got addr=%h count=%0d wrData=%h required 0",
                 ymem_addr, wb_wrCount, ymem_wrData);
      end
    end
    wb_inValid = 1'b0; reset = 1'b1;
    ref_count = 0; ref_err = 1'b0; ref_done = 1'b0;
    @(negedge clock);
    tests_run++;
    if (wb_inReady !== 1'b1) begin
      tests_failed++; $display("FAIL reset_release_ready: got %b required 1", wb_inReady);
    end
    tests_run++;
    if (rd_pulses != rd0 || wr_pulses != wr0) begin
      tests_failed++; $display("FAIL reset_strobes: got rd=%0d wr=%0d required 0 0",
                               rd_pulses - rd0, wr_pulses - wr0);
    end
  endtask

  logic [47:0] v0, v1, v2, v3;

  task automatic test_hit();
    int rd0, wr0, n;
    logic [255:0] exp_row;
    v0 = {$urandom, $urandom}; v1 = {$urandom, $urandom};
    v2 = {$urandom, $urandom}; v3 = {$urandom, $urandom};
    preload(5, {16'h0007, v3, 16'h0003, v2, 16'hFFFF, v1, 16'h0001, v0});
    rd0 = rd_pulses; wr0 = wr_pulses;
    send_entry(5, 16'd3, 48'h000001_FFFFFF, 1'b0);
    model_entry(5, 16'd3, 48'h000001_FFFFFF, 1'b0);
    wait_idle(n);
    exp_row = {16'h0007, v3, 16'h0003, 48'h000001_FFFFFF, 16'hFFFF, v1, 16'h0001, v0};
    tests_run++;
    if (mem[5] !== exp_row || ref_mem[5] !== exp_row) begin
      tests_failed++; $display("FAIL hit_row: got %h required %h", mem[5], exp_row);
    end
    tests_run++;
    if (rd_pulses - rd0 != 1 || wr_pulses - wr0 != 1) begin
      tests_failed++; $display("FAIL hit_strobes: got rd=%0d wr=%0d required 1 1",
                               rd_pulses - rd0, wr_pulses - wr0);
    end
    tests_run++;
    if (wr_cyc - rd_cyc != 3) begin
      tests_failed++; $display("FAIL hit_rd_to_wr: got %0d required 3", wr_cyc - rd_cyc);
    end
    tests_run++;
    if (n != 5) begin
      tests_failed++; $display("FAIL hit_ready_latency: got %0d required 5", n);
    end
    tests_run++;
    if (wb_wrCount !== 16'd1) begin
      tests_failed++; $display("FAIL hit_count: got %0d required 1", wb_wrCount);
    end
    check_status("hit");
  endtask

  task automatic test_insert();
    int n;
    logic [47:0] val = {$urandom, $urandom};
    logic [255:0] exp_row;
    send_entry(5, 16'd9, val, 1'b0);
    model_entry(5, 16'd9, val, 1'b0);
    wait_idle(n);
    exp_row = {16'h0007, v3, 16'h0003, 48'h000001_FFFFFF, 16'h0009, val, 16'h0001, v0};
    tests_run++;
    if (mem[5] !== exp_row || ref_mem[5] !== exp_row) begin
      tests_failed++; $display("FAIL insert_row: got %h required %h", mem[5], exp_row);
    end
    check_status("insert");
  endtask

  task automatic test_random();
    int n;
    logic [255:0] r;
    logic [15:0] col;
    logic [47:0] val;
    logic last;
    int a;
    for (int i = 10; i < 14; i++) begin
      for (int s = 0; s < 4; s++) begin
        col = 16'($urandom_range(0, 6));
        if (col == 16'd6) col = 16'hFFFF;
        r[64*s +: 64] = {col, 16'($urandom), 32'($urandom)};
      end
      preload(i, r);
    end
    for (int k = 0; k < 30; k++) begin
      a = 10 + int'($urandom_range(0, 3));
      col = 16'($urandom_range(0, 7));
      if (col == 16'd7) col = 16'hFFFF;
      val = {16'($urandom), 32'($urandom)};
      last = ($urandom_range(0, 9) == 0);
      send_entry(a, col, val, last);
      model_entry(a, col, val, last);
      wait_idle(n);
      tests_run++;
      if (mem[a] !== ref_mem[a]) begin
        tests_failed++; $display("FAIL random_row[%0d]: got %h required %h", k, mem[a], ref_mem[a]);
      end
      check_status("random");
    end
  endtask

  task automatic test_stream();
    int n, wr0;
    logic [255:0] prev;
    logic [15:0] cols [3] = '{16'd2, 16'd8, 16'd2};
    logic [47:0] val;
    do_reset();
    preload(64, {16'hFFFF, 48'd0, 16'h0002, 48'h123456_654321, 16'hFFFF, 48'd0, 16'h0004, 48'h0000AA_0000BB});
    for (int k = 0; k < 3; k++) begin
      prev = ref_mem[64];
      val = {16'($urandom), 32'($urandom)};
      send_entry(64, cols[k], val, k == 2);
      model_entry(64, cols[k], val, k == 2);
      wait_idle(n);
      tests_run++;
      if (last_rd_data !== prev) begin
        tests_failed++; $display("FAIL stream_read[%0d]: got %h required %h", k, last_rd_data, prev);
      end
      tests_run++;
      if (mem[64] !== ref_mem[64]) begin
        tests_failed++; $display("FAIL stream_row[%0d]: got %h required %h", k, mem[64], ref_mem[64]);
      end
      tests_run++;
      if (wb_done !== (k == 2)) begin
        tests_failed++; $display("FAIL stream_done[%0d]: got %b required %b", k, wb_done, k == 2);
      end
    end
    tests_run++;
    if (wb_wrCount !== 16'd3) begin
      tests_failed++; $display("FAIL stream_count: got %0d required 3", wb_wrCount);
    end
    // Abort a transaction during WAIT.
    prev = mem[64];
    send_entry(64, 16'd4, 48'hABCDEF_012345, 1'b1);
    @(negedge clock);
    @(negedge clock);
    wr0 = wr_pulses;
    reset = 1'b0;
    @(negedge clock);
    tests_run++;
    if ({ymem_rdEn, ymem_wrEn, wb_done, wb_err, wb_inReady} !== 5'b0 ||
        wb_wrCount !== 16'd0 || ymem_addr !== 11'd0 || ymem_wrData !== 256'd0) begin
      tests_failed++;
      $display("FAIL abort_clear: got rd=%b wr=%b done=%b err=%b ready=%b count=%0d required all 0",
               ymem_rdEn, ymem_wrEn, wb_done, wb_err, wb_inReady, wb_wrCount);
    end
    reset = 1'b1;
    ref_count = 0; ref_err = 1'b0; ref_done = 1'b0;
    repeat (6) @(negedge clock);
    tests_run++;
    if (wr_pulses != wr0 || mem[64] !== prev) begin
      tests_failed++; $display("FAIL abort_no_write: got %0d writes required 0", wr_pulses - wr0);
    end
    tests_run++;
    if (wb_inReady !== 1'b1) begin
      tests_failed++; $display("FAIL abort_ready: got %b required 1", wb_inReady);
    end
  endtask

  task automatic test_illegal();
    int n, rd0 = rd_pulses;
    send_entry(5, 16'hFFFF, 48'h111111_222222, 1'b1);
    model_entry(5, 16'hFFFF, 48'h111111_222222, 1'b1);
    wait_idle(n);
    tests_run++;
    if (rd_pulses != rd0) begin
      tests_failed++; $display("FAIL illegal_no_read: got %0d reads required 0", rd_pulses - rd0);
    end
    tests_run++;
    if (wb_err !== 1'b1 || wb_done !== 1'b1) begin
      tests_failed++; $display("FAIL illegal_flags: got err=%b done=%b required 1 1", wb_err, wb_done);
    end
    check_status("illegal");
  endtask

  task automatic test_overflow();
    int n, wr0;
    logic [255:0] full = {16'd4, 48'h4, 16'd3, 48'h3, 16'd2, 48'h2, 16'd1, 48'h1};
    preload(291, full);
    wr0 = wr_pulses;
    send_entry(291, 16'd5, 48'h555555_555555, 1'b0);
    model_entry(291, 16'd5, 48'h555555_555555, 1'b0);
    wait_idle(n);
    tests_run++;
    if (wr_pulses != wr0 || mem[291] !== full) begin
      tests_failed++; $display("FAIL overflow_no_write: got %0d writes required 0", wr_pulses - wr0);
    end
    tests_run++;
    if (wb_err !== 1'b1 || wb_wrCount !== 16'd0) begin
      tests_failed++; $display("FAIL overflow_err: got err=%b count=%0d required 1 0", wb_err, wb_wrCount);
    end
    tests_run++;
    if (n != 4) begin
      tests_failed++; $display("FAIL overflow_ready_latency: got %0d required 4", n);
    end
  endtask

  task automatic test_strobes();
    tests_run++;
    if (both_cnt != 0 || idle_strobe != 0) begin
      tests_failed++; $display("FAIL strobe_rules: got both=%0d idle=%0d required 0 0",
                               both_cnt, idle_strobe);
    end
  endtask

  initial begin
    reset = 1'b0; wb_inValid = 1'b0; wb_addr = '0; wb_col = '0; wb_yVal = '0; wb_last = 1'b0;
    ref_count = 0; ref_err = 1'b0; ref_done = 1'b0;
    repeat (2) @(negedge clock);
    test_reset();
    test_hit();
    test_insert();
    test_random();
    test_stream();
    test_illegal();
    do_reset();
    test_overflow();
    test_strobes();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
